// File: rtl/gpio_bank_if.sv
// gpio_bank_if -- register bus bundle for gpio_bank.
//
// Bus protocol: sel_in qualifies a single-cycle access and ready_out mirrors
// sel_in, so every selected cycle completes in that cycle. A write commits
// at the rising edge where sel_in = 1, byte lanes gated by write_mask_in.
// read_value_out is combinational from the registers, and it is zero whenever
// sel_in = 0 so several slaves can be OR-combined onto one bus.
//
// Signals:
//   address_in      master->slave  32  byte address, bits [4:2] decoded
//   sel_in          master->slave   1  block selected this cycle
//   read_in         master->slave   1  read strobe (reads have no side effects)
//   write_mask_in   master->slave   4  byte-lane write enables
//   write_value_in  master->slave  32  write data
//   read_value_out  slave->master  32  read data
//   ready_out       slave->master   1  access complete
interface gpio_bank_if;
  logic [31:0] address_in;
  logic        sel_in;
  logic        read_in;
  logic [3:0]  write_mask_in;
  logic [31:0] write_value_in;
  logic [31:0] read_value_out;
  logic        ready_out;

  modport slave (
    input  address_in, sel_in, read_in, write_mask_in, write_value_in,
    output read_value_out, ready_out
  );

  modport master (
    output address_in, sel_in, read_in, write_mask_in, write_value_in,
    input  read_value_out, ready_out
  );
endinterface

// File: rtl/gpio_bank.sv
// gpio_bank -- WIDTH-channel GPIO block with input synchronisers, per-pin
// debounce filters and edge interrupts.
//
// Register map (byte offset, address bits [4:2] decoded):
//   0x00 OUT (RW)  0x04 DIR (RW)  0x08 IN (RO)  0x0C RISE_EN (RW)
//   0x10 FALL_EN (RW)  0x14 PENDING (RW1C)  0x18 DEB_EN (RW)  0x1C reserved
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   bus       gpio_bank_if slave modport (register access)
//   pins_in   raw asynchronous pin inputs
//   pins_out  OUT register to pads
//   pins_oe   DIR register to pads (1 = drive)
//   irq_out   OR of PENDING, level
module gpio_bank #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 36000
) (
  input  logic             clk,
  input  logic             reset,
  gpio_bank_if.slave       bus,
  input  logic [WIDTH-1:0] pins_in,
  output logic [WIDTH-1:0] pins_out,
  output logic [WIDTH-1:0] pins_oe,
  output logic             irq_out
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW:0]   DEB_TH  = (CW+1)'(DEBOUNCE_CYCLES);
  localparam logic [CW:0]   ONE_TH  = (CW+1)'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [2:0] A_OUT  = 3'd0;
  localparam logic [2:0] A_DIR  = 3'd1;
  localparam logic [2:0] A_IN   = 3'd2;
  localparam logic [2:0] A_RISE = 3'd3;
  localparam logic [2:0] A_FALL = 3'd4;
  localparam logic [2:0] A_PEND = 3'd5;
  localparam logic [2:0] A_DEB  = 3'd6;

  // Zero-extend a channel vector to the 32-bit bus width.
  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  // Replace the enabled byte lanes of old with the matching lanes of wd.
  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] wd,
                                        input logic [3:0]  m);
    logic [31:0] r;
    r = old;
    for (int n = 0; n < 4; n++) begin
      if (m[n]) r[8*n +: 8] = wd[8*n +: 8];
    end
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] write_reg(input logic [WIDTH-1:0] old,
                                                 input logic [31:0]      wd,
                                                 input logic [3:0]       m);
    logic [31:0] r;
    r = merge(zext(old), wd, m);
    return r[WIDTH-1:0];
  endfunction

  logic [WIDTH-1:0] out_q,     out_d;
  logic [WIDTH-1:0] dir_q,     dir_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] pend_q,    pend_d;
  logic [WIDTH-1:0] deb_en_q,  deb_en_d;
  logic [WIDTH-1:0] stable_q,  stable_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];

  logic [WIDTH-1:0] sync_w;
  logic [WIDTH-1:0] rise_w;
  logic [WIDTH-1:0] fall_w;
  logic [31:0]      clr_w;
  logic [2:0]       addr_w;
  logic             wr_w;
  logic [31:0]      rdata_w;
  logic             unused_bus;

  assign addr_w = bus.address_in[4:2];
  assign wr_w   = bus.sel_in;
  // Only the enabled lanes of a PENDING write carry clear bits.
  assign clr_w  = merge(32'h0, bus.write_value_in, bus.write_mask_in);
  assign sync_w = sync_q[SYNC_STAGES-1];

  assign unused_bus = ^{bus.address_in[31:5], bus.address_in[1:0], bus.read_in};

  // Input synchroniser chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= pins_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // Debounce filter and edge detection.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync_w[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (({1'b0, cnt_q[i]} + ONE_TH) >= (deb_en_q[i] ? DEB_TH : ONE_TH)) begin
        // Threshold follows DEB_EN immediately; a retained count above a
        // freshly lowered threshold toggles on the next differing edge.
        stable_d[i] = ~stable_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
    rise_w = stable_d & ~stable_q & rise_en_q;
    fall_w = ~stable_d & stable_q & fall_en_q;
  end

  // Register writes.
  always_comb begin
    out_d     = out_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    deb_en_d  = deb_en_q;
    pend_d    = pend_q;
    if (wr_w) begin
      case (addr_w)
        A_OUT:   out_d     = write_reg(out_q,     bus.write_value_in, bus.write_mask_in);
        A_DIR:   dir_d     = write_reg(dir_q,     bus.write_value_in, bus.write_mask_in);
        A_RISE:  rise_en_d = write_reg(rise_en_q, bus.write_value_in, bus.write_mask_in);
        A_FALL:  fall_en_d = write_reg(fall_en_q, bus.write_value_in, bus.write_mask_in);
        A_DEB:   deb_en_d  = write_reg(deb_en_q,  bus.write_value_in, bus.write_mask_in);
        A_PEND:  pend_d    = pend_q & ~clr_w[WIDTH-1:0];
        default: ;
      endcase
    end
    // Set is applied after clear so a coincident edge wins.
    pend_d = pend_d | rise_w | fall_w;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      pend_q    <= '0;
      deb_en_q  <= '0;
      stable_q  <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      out_q     <= out_d;
      dir_q     <= dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      pend_q    <= pend_d;
      deb_en_q  <= deb_en_d;
      stable_q  <= stable_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Read mux, zero when not selected.
  always_comb begin
    rdata_w = '0;
    if (bus.sel_in) begin
      case (addr_w)
        A_OUT:   rdata_w = zext(out_q);
        A_DIR:   rdata_w = zext(dir_q);
        A_IN:    rdata_w = zext(stable_q);
        A_RISE:  rdata_w = zext(rise_en_q);
        A_FALL:  rdata_w = zext(fall_en_q);
        A_PEND:  rdata_w = zext(pend_q);
        A_DEB:   rdata_w = zext(deb_en_q);
        default: rdata_w = '0;
      endcase
    end
  end

  assign bus.read_value_out = rdata_w;
  assign bus.ready_out      = bus.sel_in;
  assign pins_out           = out_q;
  assign pins_oe            = dir_q;
  assign irq_out            = |pend_q;

endmodule
